// File: rtl/resp_uart_pkg.sv
// Shared types and constants for the response UART transmitter.
package resp_uart_pkg;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} tx_state_t;

  localparam int FRAME_BITS = 10;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/resp_fifo.sv
// Small synchronous FIFO with registered full/empty flags and a sticky overflow flag.
module resp_fifo
  import resp_uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             ovf
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count, count_nxt;
  logic             wr_en, rd_en;

  // Decisions use the registered flags, so a push into an empty FIFO never pops that cycle.
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign dout  = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (wr_en && !rd_en) count_nxt = count + CNT_ONE;
    else if (rd_en && !wr_en) count_nxt = count - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      ovf    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == CNT_FULL);
      empty <= (count_nxt == '0);
      if (push && full) ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/resp_uart_tx.sv
// 8N1 UART transmitter draining a byte FIFO; one idle-high cycle separates back-to-back frames.
module resp_uart_tx
  import resp_uart_pkg::*;
#(
  parameter int BAUD_DIV = 434,
  parameter int DEPTH    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send_resp,
  input  logic [7:0] resp_data,
  output logic       TX,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       tx_done,
  output logic       ovf
);

  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [3:0]    LAST_BIT  = 4'(FRAME_BITS - 1);

  tx_state_t             state, state_nxt;
  logic                  pop, bit_end, frame_end, tx_done_q;
  logic [7:0]            head;
  logic [BW-1:0]         baud_cnt;
  logic [3:0]            bit_cnt;
  logic [FRAME_BITS-1:0] shift_reg;

  resp_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (send_resp),
    .pop   (pop),
    .din   (resp_data),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .ovf   (ovf)
  );

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    frame_end = 1'b0;
    bit_end   = (baud_cnt == BAUD_LAST);
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_end && bit_cnt == LAST_BIT) begin
          frame_end = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tx_done_q <= 1'b0;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      tx_done_q <= frame_end;
      if (pop) begin
        baud_cnt <= '0;
        bit_cnt  <= '0;
      end else if (state == SHIFT) begin
        if (bit_end) begin
          baud_cnt <= '0;
          bit_cnt  <= bit_cnt + 4'd1;
        end else begin
          baud_cnt <= baud_cnt + BW'(1);
        end
      end
    end
  end

  // Frame is stop, data[7:0], start from MSB to LSB; shifting in ones keeps the line high at the end.
  always_ff @(posedge clk) begin
    if (pop) shift_reg <= {1'b1, head, 1'b0};
    else if (state == SHIFT && bit_end) shift_reg <= {1'b1, shift_reg[FRAME_BITS-1:1]};
  end

  assign busy    = (state == SHIFT);
  assign TX      = busy ? shift_reg[0] : IDLE_LEVEL;
  assign tx_done = tx_done_q && !rst;

endmodule

// File: tb/tb_resp_uart_tx.sv
// Scoreboard bench: a timeline model predicts accepted bytes and frame timing; a line decoder checks them.
module tb_resp_uart_tx;

  localparam int B     = 4;
  localparam int DEPTH = 4;
  localparam int FB    = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       send_resp = 1'b0;
  logic [7:0] resp_data = 8'h00;
  logic       TX, full, empty, busy, tx_done, ovf;

  logic       send2 = 1'b0;
  logic [7:0] data2 = 8'h00;
  logic       tx2, full2, empty2, busy2, done2, ovf2;

  resp_uart_tx #(.BAUD_DIV(B), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .send_resp(send_resp), .resp_data(resp_data),
    .TX(TX), .full(full), .empty(empty), .busy(busy), .tx_done(tx_done), .ovf(ovf)
  );

  resp_uart_tx #(.BAUD_DIV(434), .DEPTH(4)) u_nom (
    .clk(clk), .rst(rst), .send_resp(send2), .resp_data(data2),
    .TX(tx2), .full(full2), .empty(empty2), .busy(busy2), .tx_done(done2), .ovf(ovf2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int failures = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endfunction

  // Timeline model: each accepted byte pops at max(push+1, previous tx_done cycle).
  typedef struct {int push_c; int pop_c;} acc_t;
  typedef struct {logic [7:0] d; int start;} exp_t;
  acc_t acc[$];
  exp_t exp_q[$];
  int   next_pop = 0;
  int   drop_c = -1;

  function automatic void model_reset();
    acc.delete();
    exp_q.delete();
    next_pop = 0;
    drop_c = -1;
  endfunction

  function automatic int model_count(input int c);
    int n = 0;
    foreach (acc[i]) if (acc[i].push_c < c && acc[i].pop_c >= c) n++;
    return n;
  endfunction

  function automatic void model_push(input logic [7:0] d, input int c);
    int occ;
    int p;
    while (acc.size() > 0 && acc[0].pop_c < c) void'(acc.pop_front());
    occ = model_count(c);
    if (occ >= DEPTH) begin
      if (drop_c < 0) drop_c = c;
    end else begin
      p = (c + 1 > next_pop) ? c + 1 : next_pop;
      next_pop = p + 1 + FB * B;
      acc.push_back('{c, p});
      exp_q.push_back('{d, p + 1});
    end
  endfunction

  // Line monitor: decodes frames mid-bit and checks them against the scoreboard.
  bit         mon_active = 1'b0;
  int         mon_start = 0;
  logic [9:0] mon_bits;
  logic [7:0] rx_log[$];
  int         done_log[$];

  always @(negedge clk) begin
    int   rel;
    exp_t e;
    if (rst) begin
      mon_active = 1'b0;
      chk("tx_done_during_rst", tx_done, 1'b0);
    end else begin
      chk("empty", empty, model_count(cyc) == 0);
      chk("full", full, model_count(cyc) == DEPTH);
      chk("ovf", ovf, drop_c >= 0 && drop_c < cyc);
      if (!mon_active && TX === 1'b0) begin
        mon_active = 1'b1;
        mon_start = cyc;
      end
      if (mon_active) begin
        rel = cyc - mon_start;
        if (rel < FB * B) begin
          if (rel % B == B / 2) mon_bits[rel / B] = TX;
          chk("busy_in_frame", busy, 1'b1);
          chk("tx_done_in_frame", tx_done, 1'b0);
        end else begin
          chk("busy_after_frame", busy, 1'b0);
          chk("tx_done_pulse", tx_done, 1'b1);
          chk("tx_idle_gap", TX, 1'b1);
          chk("start_bit", mon_bits[0], 1'b0);
          chk("stop_bit", mon_bits[9], 1'b1);
          if (exp_q.size() == 0) begin
            chk("unexpected_frame", {24'h0, mon_bits[8:1]}, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("frame_data", mon_bits[8:1], e.d);
            chk("frame_start_cycle", mon_start, e.start);
          end
          rx_log.push_back(mon_bits[8:1]);
          done_log.push_back(cyc);
          mon_active = 1'b0;
        end
      end else begin
        chk("busy_idle", busy, 1'b0);
        chk("tx_done_idle", tx_done, 1'b0);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_byte(input logic [7:0] d);
    send_resp = 1'b1;
    resp_data = d;
    model_push(d, cyc);
    tick(1);
    send_resp = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((exp_q.size() != 0 || mon_active || busy || !empty) && n < 2000) begin
      tick(1);
      n++;
    end
    chk(nm, n < 2000, 1'b1);
    tick(2);
  endtask

  task automatic clear_logs();
    rx_log.delete();
    done_log.delete();
  endtask

  initial begin
    int t0;
    int low_seen;
    int fall_c, rise_c, done_c;
    logic [7:0] rnd;
    logic [7:0] ovf_exp [5];

    model_reset();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_TX", TX, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_tx_done", tx_done, 1'b0);
    chk("reset_full", full, 1'b0);
    chk("reset_empty", empty, 1'b1);
    chk("reset_ovf", ovf, 1'b0);
    tick(2);

    // Single byte
    clear_logs();
    t0 = cyc;
    push_byte(8'hA5);
    drain("drain_single");
    chk("single_done_count", done_log.size(), 1);
    if (done_log.size() == 1) chk("single_done_cycle", done_log[0] - t0, 42);
    if (rx_log.size() == 1) chk("single_data", rx_log[0], 8'hA5);

    // Back-to-back frames
    clear_logs();
    t0 = cyc;
    push_byte(8'h00);
    push_byte(8'hFF);
    push_byte(8'h55);
    drain("drain_b2b");
    chk("b2b_done_count", done_log.size(), 3);
    if (done_log.size() == 3) begin
      chk("b2b_done0", done_log[0] - t0, 42);
      chk("b2b_done1", done_log[1] - t0, 83);
      chk("b2b_done2", done_log[2] - t0, 124);
    end
    chk("b2b_empty", empty, 1'b1);

    // Simultaneous push and pop
    clear_logs();
    t0 = cyc;
    push_byte(8'h11);
    push_byte(8'h22);
    @(negedge clk);
    chk("simul_count_one_empty", empty, 1'b0);
    chk("simul_count_one_full", full, 1'b0);
    drain("drain_simul");
    chk("simul_done_count", done_log.size(), 2);
    if (done_log.size() == 2) begin
      chk("simul_done0", done_log[0] - t0, 42);
      chk("simul_done1", done_log[1] - t0, 83);
      chk("simul_data0", rx_log[0], 8'h11);
      chk("simul_data1", rx_log[1], 8'h22);
    end

    // Overflow
    clear_logs();
    t0 = cyc;
    for (int i = 1; i <= 5; i++) push_byte(8'(i));
    @(negedge clk);
    chk("ovf_full_at_5", full, 1'b1);
    push_byte(8'h06);
    @(negedge clk);
    chk("ovf_flag", ovf, 1'b1);
    drain("drain_ovf");
    ovf_exp = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    chk("ovf_frame_count", rx_log.size(), 5);
    if (rx_log.size() == 5) foreach (ovf_exp[i]) chk("ovf_data", rx_log[i], ovf_exp[i]);

    // Reset mid-frame
    clear_logs();
    t0 = cyc;
    push_byte(8'h3C);
    push_byte(8'h7E);
    tick(13);
    rst = 1'b1;
    model_reset();
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_TX", TX, 1'b1);
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_empty", empty, 1'b1);
    chk("rstmid_ovf", ovf, 1'b0);
    low_seen = 0;
    for (int i = 0; i < 60; i++) begin
      tick(1);
      if (TX !== 1'b1) low_seen++;
    end
    chk("rstmid_line_high", low_seen, 0);
    chk("rstmid_no_done", done_log.size(), 0);
    push_byte(8'h42);
    drain("drain_rstmid");
    chk("rstmid_new_count", rx_log.size(), 1);
    if (rx_log.size() == 1) chk("rstmid_new_data", rx_log[0], 8'h42);

    // Randomized traffic, including bursts that overflow
    clear_logs();
    for (int i = 0; i < 40; i++) begin
      rnd = 8'($urandom_range(0, 255));
      push_byte(rnd);
      if ($urandom_range(0, 3) == 0) tick($urandom_range(0, 2));
      else tick($urandom_range(20, 60));
    end
    drain("drain_random");

    // Nominal baud on the second instance
    t0 = cyc;
    send2 = 1'b1;
    data2 = 8'h0D;
    tick(1);
    send2 = 1'b0;
    fall_c = -1;
    rise_c = -1;
    done_c = -1;
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (fall_c < 0 && tx2 === 1'b0) fall_c = cyc;
      else if (fall_c >= 0 && rise_c < 0 && tx2 === 1'b1) rise_c = cyc;
      if (done2 === 1'b1) begin
        done_c = cyc;
        break;
      end
    end
    chk("nom_start_cycle", fall_c - t0, 2);
    chk("nom_start_len", rise_c - fall_c, 434);
    chk("nom_done_latency", done_c - t0, 4342);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
